// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, the two cache controllers and the memory model.
// The slave modport is the arbiter's view; master is the caches plus memory side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_LEN = 8
);
  localparam int unsigned IDX_W = $clog2(BURST_LEN);

  logic              icache_req;
  logic [ADDR_W-1:0] icache_addr;
  logic              icache_done;
  logic              dcache_req;
  logic              dcache_we;
  logic [ADDR_W-1:0] dcache_addr;
  logic [DATA_W-1:0] dcache_wdata;
  logic              dcache_done;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              fill_valid;
  logic              fill_dst;
  logic [IDX_W-1:0]  fill_idx;
  logic [DATA_W-1:0] fill_data;
  logic              busy;

  modport slave (
    input  icache_req, icache_addr, dcache_req, dcache_we, dcache_addr, dcache_wdata,
           mem_data_valid, mem_rdata,
    output icache_done, dcache_done, mem_en, mem_wr, mem_addr, mem_wdata,
           fill_valid, fill_dst, fill_idx, fill_data, busy
  );

  modport master (
    output icache_req, icache_addr, dcache_req, dcache_we, dcache_addr, dcache_wdata,
           mem_data_valid, mem_rdata,
    input  icache_done, dcache_done, mem_en, mem_wr, mem_addr, mem_wdata,
           fill_valid, fill_dst, fill_idx, fill_data, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one pipelined memory port between I/D block fills and D write-through stores.
// Optional MEM_ARB_PERF_EN adds saturating fill and wait-cycle counters.
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]  perf_ifill,
  output logic [15:0]  perf_dfill,
  output logic [15:0]  perf_wait
`endif
);
  localparam int unsigned IDX_W = $clog2(BURST_LEN);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OFF_W = IDX_W + 1;

  typedef enum logic [1:0] {StIdle, StIFill, StDFill, StDWrite} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  issue_q, ret_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              last_d_q;
  logic              grant_i, grant_d, is_fill, issuing, last_ret;

  // Ties go to D unless the previous grant was D.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == StIdle) begin
      if (bus.icache_req && bus.dcache_req) begin
        grant_i = last_d_q;
        grant_d = !last_d_q;
      end else begin
        grant_i = bus.icache_req;
        grant_d = bus.dcache_req;
      end
    end
  end

  always_comb begin
    is_fill  = (state_q == StIFill) || (state_q == StDFill);
    issuing  = is_fill && (issue_q < CNT_W'(BURST_LEN));
    last_ret = is_fill && bus.mem_data_valid && (ret_q == CNT_W'(BURST_LEN - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d)      state_d = bus.dcache_we ? StDWrite : StDFill;
        else if (grant_i) state_d = StIFill;
      end
      StIFill, StDFill: if (last_ret) state_d = StIdle;
      StDWrite:         state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  // Request fields are captured at grant so requesters may change them afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q  <= '0;
      ret_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      last_d_q <= 1'b0;
    end else if (grant_i || grant_d) begin
      issue_q  <= '0;
      ret_q    <= '0;
      last_d_q <= grant_d;
      addr_q   <= grant_d ? bus.dcache_addr : bus.icache_addr;
      wdata_q  <= bus.dcache_wdata;
    end else begin
      if (issuing) issue_q <= issue_q + 1'b1;
      if (is_fill && bus.mem_data_valid) ret_q <= last_ret ? '0 : ret_q + 1'b1;
    end
  end

  always_comb begin
    bus.mem_en      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.fill_valid  = 1'b0;
    bus.fill_dst    = 1'b0;
    bus.fill_idx    = '0;
    bus.fill_data   = '0;
    bus.icache_done = 1'b0;
    bus.dcache_done = 1'b0;
    bus.busy        = (state_q != StIdle);
    unique case (state_q)
      StIFill, StDFill: begin
        if (issuing) begin
          bus.mem_en   = 1'b1;
          // Block base has zero offset bits, so base+2k is a plain concatenation.
          bus.mem_addr = {addr_q[ADDR_W-1:OFF_W], issue_q[IDX_W-1:0], 1'b0};
        end
        bus.fill_valid  = bus.mem_data_valid;
        bus.fill_dst    = (state_q == StDFill);
        bus.fill_idx    = ret_q[IDX_W-1:0];
        bus.fill_data   = bus.mem_data_valid ? bus.mem_rdata : '0;
        bus.icache_done = last_ret && (state_q == StIFill);
        bus.dcache_done = last_ret && (state_q == StDFill);
      end
      StDWrite: begin
        bus.mem_en      = 1'b1;
        bus.mem_wr      = 1'b1;
        bus.mem_addr    = addr_q;
        bus.mem_wdata   = wdata_q;
        bus.dcache_done = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_ifill_q, perf_dfill_q, perf_wait_q;
  logic        wait_cyc;

  assign wait_cyc = (state_q != StIdle) && (bus.icache_req || bus.dcache_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ifill_q <= '0;
      perf_dfill_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      if (last_ret && (state_q == StIFill) && (perf_ifill_q != 16'hFFFF)) begin
        perf_ifill_q <= perf_ifill_q + 16'd1;
      end
      if (last_ret && (state_q == StDFill) && (perf_dfill_q != 16'hFFFF)) begin
        perf_dfill_q <= perf_dfill_q + 16'd1;
      end
      if (wait_cyc && (perf_wait_q != 16'hFFFF)) perf_wait_q <= perf_wait_q + 16'd1;
    end
  end

  assign perf_ifill = perf_ifill_q;
  assign perf_dfill = perf_dfill_q;
  assign perf_wait  = perf_wait_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboarded memory commands and fill words,
// plus timing, arbitration, abort and (with MEM_ARB_PERF_EN) counter checks.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BURST_LEN = 8;
  localparam int unsigned MEM_LAT   = 4;
  localparam int unsigned IDX_W     = $clog2(BURST_LEN);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic              dst;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } fill_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_ifill, perf_dfill, perf_wait;
`endif

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_ifill (perf_ifill),
    .perf_dfill (perf_dfill),
    .perf_wait  (perf_wait)
`endif
  );

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  // Memory model: read data appears MEM_LAT cycles after the issue cycle; it has no reset.
  logic [MEM_LAT-1:0] vpipe = '0;
  logic [DATA_W-1:0]  dpipe [MEM_LAT];
  always @(posedge clk) begin
    vpipe    <= {vpipe[MEM_LAT-2:0], bus.mem_en && !bus.mem_wr};
    dpipe[0] <= mem_word(bus.mem_addr);
    for (int i = 1; i < MEM_LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign bus.mem_data_valid = vpipe[MEM_LAT-1];
  assign bus.mem_rdata      = dpipe[MEM_LAT-1];

  cmd_t  cmd_q[$];
  fill_t fill_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    first_issue_cyc = 0;
  int    last_cmd_cyc = 0;
  int    idone_n = 0, ddone_n = 0;
  int    idone_cyc = 0, ddone_cyc = 0;
  int    wait_n = 0;
  logic  prev_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_fill(input logic dst, input logic [ADDR_W-1:0] addr, input int nfill);
    logic [ADDR_W-1:0] base, a;
    base = addr & ~ADDR_W'(BURST_LEN * 2 - 1);
    for (int k = 0; k < int'(BURST_LEN); k++) begin
      a = base + ADDR_W'(2 * k);
      cmd_q.push_back('{wr: 1'b0, addr: a, data: '0});
      if (k < nfill) fill_q.push_back('{dst: dst, idx: IDX_W'(k), data: mem_word(a)});
    end
  endtask

  // Advance one cycle and score everything the DUT shows in it.
  task automatic step();
    cmd_t  c;
    fill_t f;
    @(negedge clk);
    cyc++;
    if (bus.mem_en) begin
      if (!prev_en) first_issue_cyc = cyc;
      if (cmd_q.size() == 0) begin
        check("cmd_unexpected", 32'(bus.mem_en), 32'd0);
      end else begin
        c = cmd_q.pop_front();
        check("cmd_wr", 32'(bus.mem_wr), 32'(c.wr));
        check("cmd_addr", 32'(bus.mem_addr), 32'(c.addr));
        if (c.wr) check("cmd_wdata", 32'(bus.mem_wdata), 32'(c.data));
        last_cmd_cyc = cyc;
      end
    end
    prev_en = bus.mem_en;
    if (bus.fill_valid) begin
      if (fill_q.size() == 0) begin
        check("fill_unexpected", 32'(bus.fill_valid), 32'd0);
      end else begin
        f = fill_q.pop_front();
        check("fill_dst", 32'(bus.fill_dst), 32'(f.dst));
        check("fill_idx", 32'(bus.fill_idx), 32'(f.idx));
        check("fill_data", 32'(bus.fill_data), 32'(f.data));
      end
    end
    if (bus.icache_done) begin idone_n++; idone_cyc = cyc; end
    if (bus.dcache_done) begin ddone_n++; ddone_cyc = cyc; end
    if ((bus.icache_req || bus.dcache_req) && bus.busy) wait_n++;
  endtask

  task automatic wait_done(input logic d, input int budget);
    int n0;
    n0 = d ? ddone_n : idone_n;
    for (int i = 0; i < budget; i++) begin
      step();
      if ((d ? ddone_n : idone_n) != n0) return;
    end
    check(d ? "dcache_done_timeout" : "icache_done_timeout",
          32'(d ? bus.dcache_done : bus.icache_done), 32'd1);
  endtask

  task automatic run_fill(input logic d, input logic [ADDR_W-1:0] addr);
    push_fill(d, addr, BURST_LEN);
    if (d) begin
      bus.dcache_req = 1'b1; bus.dcache_we = 1'b0; bus.dcache_addr = addr;
    end else begin
      bus.icache_req = 1'b1; bus.icache_addr = addr;
    end
    wait_done(d, 40);
    bus.icache_req = 1'b0;
    bus.dcache_req = 1'b0;
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int d1_done, i_done, drops;
    bus.icache_req   = 1'b0;
    bus.icache_addr  = '0;
    bus.dcache_req   = 1'b0;
    bus.dcache_we    = 1'b0;
    bus.dcache_addr  = '0;
    bus.dcache_wdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_fill_valid", 32'(bus.fill_valid), 32'd0);
    check("rst_dones", 32'({bus.icache_done, bus.dcache_done}), 32'd0);
    rst_n = 1'b1;
    step();

    // Lone I miss; address changes after grant must not matter.
    push_fill(1'b0, 16'h1236, BURST_LEN);
    bus.icache_req = 1'b1; bus.icache_addr = 16'h1236;
    step();
    check("ifill_busy", 32'(bus.busy), 32'd1);
    bus.icache_addr = 16'hFFFF;
    wait_done(1'b0, 40);
    check("ifill_latency", 32'(idone_cyc - first_issue_cyc + 1), 32'(BURST_LEN + MEM_LAT));
    bus.icache_req = 1'b0;
    step();
    check("ifill_idle_busy", 32'(bus.busy), 32'd0);
    check("ifill_cmds_left", 32'(cmd_q.size()), 32'd0);
    check("ifill_words_left", 32'(fill_q.size()), 32'd0);

    // Tie after reset: D, then I (last was D), then D again (last was I).
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    push_fill(1'b1, 16'h3458, BURST_LEN);
    push_fill(1'b0, 16'h2000, BURST_LEN);
    push_fill(1'b1, 16'h3470, BURST_LEN);
    bus.icache_req = 1'b1; bus.icache_addr = 16'h2000;
    bus.dcache_req = 1'b1; bus.dcache_we = 1'b0; bus.dcache_addr = 16'h3458;
    i_done = idone_n;
    wait_done(1'b1, 40);
    d1_done = ddone_cyc;
    check("tie_d_first", 32'(idone_n), 32'(i_done));
    bus.dcache_addr = 16'h3470;
    wait_done(1'b0, 40);
    check("i_after_d_gap", 32'(first_issue_cyc - d1_done), 32'd2);
    bus.icache_req = 1'b0;
    i_done = idone_cyc;
    wait_done(1'b1, 40);
    check("d_after_i_gap", 32'(first_issue_cyc - i_done), 32'd2);
    bus.dcache_req = 1'b0;
    step();
    check("tie_cmds_left", 32'(cmd_q.size()), 32'd0);
    check("tie_words_left", 32'(fill_q.size()), 32'd0);

    // Single-word store.
    cmd_q.push_back('{wr: 1'b1, addr: 16'h0040, data: 16'hBEEF});
    bus.dcache_req = 1'b1; bus.dcache_we = 1'b1;
    bus.dcache_addr = 16'h0040; bus.dcache_wdata = 16'hBEEF;
    wait_done(1'b1, 10);
    check("store_done_cycle", 32'(ddone_cyc), 32'(last_cmd_cyc));
    bus.dcache_req = 1'b0; bus.dcache_we = 1'b0;
    step();
    check("store_one_cycle", 32'(bus.mem_en), 32'd0);
    check("store_idle_busy", 32'(bus.busy), 32'd0);

    // Reset during the 5th return of a D fill.
    push_fill(1'b1, 16'h5000, 5);
    bus.dcache_req = 1'b1; bus.dcache_addr = 16'h5000;
    for (int i = 0; i < 30 && fill_q.size() != 0; i++) step();
    check("abort_reached_5th", 32'(fill_q.size()), 32'd0);
    drops = ddone_n;
    rst_n = 1'b0;
    bus.dcache_req = 1'b0;
    wait_n = 0;
    #1;
    check("abort_mem_en", 32'(bus.mem_en), 32'd0);
    check("abort_fill_valid", 32'(bus.fill_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_dcache_done", 32'(bus.dcache_done), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("abort_no_done", 32'(ddone_n), 32'(drops));
    check("abort_cmds_left", 32'(cmd_q.size()), 32'd0);

    // I request dropped after grant; a store raised meanwhile waits for IDLE.
    push_fill(1'b0, 16'h1000, BURST_LEN);
    cmd_q.push_back('{wr: 1'b1, addr: 16'h00A0, data: 16'h1234});
    bus.icache_req = 1'b1; bus.icache_addr = 16'h1000;
    step();
    step();
    step();
    bus.icache_req = 1'b0;
    bus.dcache_req = 1'b1; bus.dcache_we = 1'b1;
    bus.dcache_addr = 16'h00A0; bus.dcache_wdata = 16'h1234;
    wait_done(1'b0, 40);
    i_done = idone_cyc;
    wait_done(1'b1, 10);
    check("store_waits_idle", 32'(ddone_cyc - i_done), 32'd2);
    bus.dcache_req = 1'b0; bus.dcache_we = 1'b0;
    step();

    run_fill(1'b1, 16'h6010);
    run_fill(1'b0, 16'h7020);
    run_fill(1'b1, 16'h8030);
    run_fill(1'b0, 16'h9040);
`ifdef MEM_ARB_PERF_EN
    check("perf_ifill", 32'(perf_ifill), 32'd3);
    check("perf_dfill", 32'(perf_dfill), 32'd2);
    check("perf_wait", 32'(perf_wait), 32'(wait_n));
`endif
    check("end_cmds_left", 32'(cmd_q.size()), 32'd0);
    check("end_words_left", 32'(fill_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
